// File: rtl/expr_result_fifo_if.sv
// Result handshake bundle between the arithmetic stage, the FIFO and its consumer.
// The producer/consumer side uses master; the FIFO uses slave.
interface expr_result_fifo_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic [2*WIDTH-1:0]   in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_data
    );
endinterface

// File: rtl/expr_result_fifo.sv
// Result FIFO behind the arithmetic stage; drops pushes when full (no backpressure).
// Define EXPR_FIFO_DROP_CNT_EN to enable the saturating drop_cnt counter.
module expr_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    expr_result_fifo_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic [7:0]               drop_cnt
);
    localparam int DW = 2 * WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    always_comb begin
        pop  = !empty && bus.out_ready;
        push = bus.in_valid && (!full || pop);
        drop = bus.in_valid && full && !pop;
    end

    // Storage is not reset; out_data is masked while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef EXPR_FIFO_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = '0;
`endif

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_expr_result_fifo.sv
// Scoreboard bench for expr_result_fifo: stimulus queues expected pops,
// a negedge monitor compares every accepted head entry.
module tb_expr_result_fifo;
    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
`ifdef EXPR_FIFO_DROP_CNT_EN
    localparam logic [7:0] EXP_DROP1   = 8'd1;
    localparam logic [7:0] EXP_DROPSAT = 8'd255;
`else
    localparam logic [7:0] EXP_DROP1   = 8'd0;
    localparam logic [7:0] EXP_DROPSAT = 8'd0;
`endif

    logic        clk;
    logic        rst_n;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;
    logic [7:0]  drop_cnt;

    int n_chk;
    int n_fail;
    logic [31:0] q[$];

    expr_result_fifo_if #(.WIDTH(WIDTH)) bus ();

    expr_result_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            n_chk++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got %h, required no entry", bus.out_data);
            end else begin
                logic [31:0] e;
                e = q.pop_front();
                if (bus.out_data !== e) begin
                    n_fail++;
                    $display("FAIL pop_data: got %h, required %h", bus.out_data, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic rdy, input logic acc);
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.out_ready = rdy;
        if (acc) q.push_back(d);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic drain(input int n);
        bus.out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_queue", q.size(), 32'd0);
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_count", {29'd0, count}, 32'd0);
        q.delete();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        #12;
        chk("reset_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_empty", {31'd0, empty}, 32'd1);
        chk("reset_full", {31'd0, full}, 32'd0);
        chk("reset_count", {29'd0, count}, 32'd0);
        chk("reset_ovf", {31'd0, overflow}, 32'd0);
        chk("reset_drop", {24'd0, drop_cnt}, 32'd0);
        chk("reset_data", bus.out_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // three signed patterns, bit-exact
        push(32'h0000_0001, 1'b0, 1'b1);
        chk("lat_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_data", bus.out_data, 32'h0000_0001);
        push(32'hFFFF_FFFE, 1'b0, 1'b1);
        push(32'h7FFF_FFFF, 1'b0, 1'b1);
        chk("three_count", {29'd0, count}, 32'd3);
        @(posedge clk);
        #1;
        chk("hold_data", bus.out_data, 32'h0000_0001);
        drain(3);

        // overflow on full
        push(32'h8000_0000, 1'b0, 1'b1);
        push(32'h0000_FFFF, 1'b0, 1'b1);
        push(32'hFFFF_0000, 1'b0, 1'b1);
        push(32'h5555_AAAA, 1'b0, 1'b1);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_ovf", {31'd0, overflow}, 32'd0);
        push(32'h1234_5678, 1'b0, 1'b0);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {29'd0, count}, 32'd4);
        chk("ovf_drop", {24'd0, drop_cnt}, {24'd0, EXP_DROP1});
        drain(4);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);

        // push+pop when full
        do_reset();
        chk("rst_ovf_clr", {31'd0, overflow}, 32'd0);
        push(32'h0000_0010, 1'b0, 1'b1);
        push(32'h0000_0020, 1'b0, 1'b1);
        push(32'h0000_0030, 1'b0, 1'b1);
        push(32'h0000_0040, 1'b0, 1'b1);
        push(32'hAAAA_0000, 1'b1, 1'b1);
        chk("fullpp_count", {29'd0, count}, 32'd4);
        chk("fullpp_ovf", {31'd0, overflow}, 32'd0);
        drain(4);

        // push into empty with ready high must not pop
        push(32'h0000_0005, 1'b1, 1'b1);
        chk("emp_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("emp_data", bus.out_data, 32'h0000_0005);
        chk("emp_count", {29'd0, count}, 32'd1);
        drain(1);

        // pointer wrap under streaming
        for (int i = 0; i < 10; i++) begin
            push(32'h0101_0101 * (i + 1), 1'b1, 1'b1);
        end
        chk("wrap_count", {29'd0, count}, 32'd1);
        drain(1);

        // saturating drop counter
        for (int i = 0; i < 4; i++) begin
            push(32'hC0DE_0000 + i, 1'b0, 1'b1);
        end
        for (int i = 0; i < 300; i++) begin
            push(32'hDEAD_0000 + i, 1'b0, 1'b0);
        end
        chk("sat_drop", {24'd0, drop_cnt}, {24'd0, EXP_DROPSAT});
        chk("sat_count", {29'd0, count}, 32'd4);
        drain(4);

        // asynchronous reset mid-operation
        push(32'h0000_0001, 1'b0, 1'b1);
        push(32'h0000_0002, 1'b0, 1'b1);
        push(32'h0000_0003, 1'b0, 1'b1);
        chk("pre_rst_count", {29'd0, count}, 32'd3);
        do_reset();
        chk("post_rst_drop", {24'd0, drop_cnt}, 32'd0);
        push(32'h0000_0009, 1'b0, 1'b1);
        chk("post_rst_head", bus.out_data, 32'h0000_0009);
        drain(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/expr_result_fifo.md
EXPR_RESULT_FIFO -- requirements
Module: expr_result_fifo

Interface
REQ-001 Parameter WIDTH, default 16: operand width of the upstream arithmetic stage; data width here is 2*WIDTH.
REQ-002 Parameter DEPTH, default 4: number of result entries; power of two, at least 2.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  one-cycle pulse marking a result from the upstream arithmetic stage; no backpressure path exists.
REQ-006 in_data  input  2*WIDTH  signed result, sampled when in_valid=1.
REQ-007 out_valid  output  1  head entry available.
REQ-008 out_ready  input  1  consumer accepts head entry.
REQ-009 out_data  output  2*WIDTH  signed head entry, valid when out_valid=1.
REQ-010 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-011 full / empty  output  1 each  count==DEPTH / count==0.
REQ-012 overflow  output  1  sticky flag: a push was dropped.
REQ-013 drop_cnt  output  8  number of dropped pushes (see Configuration).

Function
REQ-014 Push shall occur when in_valid=1 and either count<DEPTH or a pop occurs in the same cycle.
REQ-015 Pop shall occur when out_valid=1 and out_ready=1.
REQ-016 out_valid shall equal !empty, and out_data shall be the oldest stored entry, driven from registered storage with no combinational path from in_data.
REQ-017 Write-to-read latency: a push at edge N makes out_valid=1 with that data after edge N, when the FIFO was empty.
REQ-018 A push into an empty FIFO with out_ready=1 in the same cycle shall not pop; the entry shall remain stored.
REQ-019 A simultaneous push and pop when full shall accept the push, and count shall stay at DEPTH.
REQ-020 A simultaneous push and pop when partially full shall leave count unchanged and keep FIFO order.
REQ-021 A push when full without a pop shall be dropped: storage unchanged, overflow set to 1 on the next edge.
REQ-022 overflow shall stay 1 until reset.
REQ-023 Read and write pointers shall wrap modulo DEPTH; order is preserved across the wrap.
REQ-024 Data shall be stored bit-exact: no sign extension, truncation or arithmetic.
REQ-025 out_valid shall never deassert without a pop.
REQ-026 out_data shall not change while out_valid=1 and out_ready=0.

Reset
REQ-027 rst_n=0 shall immediately clear the pointers, count, overflow and drop_cnt, and force out_valid=0, empty=1 and full=0, regardless of clk.
REQ-028 Storage contents need no reset, but out_data shall read 0 while empty.
REQ-029 Reset asserted mid-operation shall discard all entries; the first push after rst_n rises shall be the head entry.

Configuration
REQ-030 Macro EXPR_FIFO_DROP_CNT_EN: when defined, drop_cnt shall increment by 1 per dropped push, saturate at 255 and clear only on reset.
REQ-031 When EXPR_FIFO_DROP_CNT_EN is undefined, drop_cnt shall be constant 0 with no counter logic; overflow behaviour is unchanged.

Verification
REQ-032 Reset, then push 0x0000_0001, 0xFFFF_FFFE, 0x7FFF_FFFF with out_ready=0 -> count=3; with out_ready=1, pops return the same three values in order, bit-exact.
REQ-033 Fill 4 entries, then push 0x1234_5678 with out_ready=0 -> overflow=1, count=4, drained data excludes 0x1234_5678, drop_cnt=1 with the macro and 0 without.
REQ-034 Full FIFO, in_valid=1 and out_ready=1 in the same cycle with data 0xAAAA_0000 -> count stays 4, overflow stays 0, 0xAAAA_0000 is the last of the drained entries.
REQ-035 Empty FIFO, in_valid=1 with 0x0000_0005 and out_ready=1 in the same cycle -> next cycle out_valid=1, out_data=0x0000_0005, count=1.
REQ-036 10 pushes with continuous out_ready=1 (pointer wrap), then 300 drops on a full FIFO -> order preserved, drop_cnt=255 (macro on).
REQ-037 Assert rst_n=0 asynchronously between edges while count=3 -> out_valid=0 and count=0 immediately; after release, a push of 0x0000_0009 is the head entry.
